seq_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 17 +
 rtl/shift_step.sv | 52 +++++
 rtl/seq_shifter.sv | 102 ++++++++++
 tb/tb_seq_shifter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared op and state encodings for seq_shifter (SEQ_SHIFTER_ROR_EN-aware)
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } sh_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift of 1..STEP positions; SEQ_SHIFTER_ROR_EN adds rotate-right on op 00
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
)
(
    input  logic [WIDTH-1:0] value,
    input  shift_op_t        op,
    input  logic [AW-1:0]    k,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    // kneg wraps to WIDTH-k; k is never 0 while the result is consumed
    logic [AW-1:0] kneg;
    logic [AW-1:0] klow;

    assign kneg = AW'(0) - k;
    assign klow = k - AW'(1);

    always_comb begin
        result = value;
        cout   = 1'b0;
        case (op)
            SH_LSL: begin
                result = value << k;
                cout   = value[kneg];
            end
            SH_LSR: begin
                result = value >> k;
                cout   = value[klow];
            end
            SH_ASR: begin
                result = unsigned'($signed(value) >>> k);
                cout   = value[klow];
            end
            default: begin
`ifdef SEQ_SHIFTER_ROR_EN
                result = (value >> k) | (value << kneg);
                cout   = value[klow];
`else
                result = value;
                cout   = 1'b0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle variable shifter, STEP positions per clock; SEQ_SHIFTER_ROR_EN makes op 00 rotate right
module seq_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    sh_state_t        state, state_nxt;
    shift_op_t        op_q;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] step_val;
    logic             step_cout;
    logic             accept;
    logic             zero_amt;

    assign accept = start && (state != S_SHIFT);

`ifdef SEQ_SHIFTER_ROR_EN
    assign zero_amt = (amount == '0);
`else
    assign zero_amt = (amount == '0) || (op == SH_PASS);
`endif

    assign k = (rem > AMT_W'(STEP)) ? AMT_W'(STEP) : rem;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AW    (AMT_W)
    ) u_step (
        .value  (dout),
        .op     (op_q),
        .k      (k),
        .result (step_val),
        .cout   (step_cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_SHIFT: begin
                busy = 1'b1;
                if (rem == k) begin
                    state_nxt = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (accept) begin
                    state_nxt = zero_amt ? S_DONE : S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            carry <= 1'b0;
            rem   <= '0;
            op_q  <= SH_PASS;
        end else if (accept) begin
            dout  <= din;
            carry <= 1'b0;
            op_q  <= shift_op_t'(op);
            rem   <= zero_amt ? '0 : amount;
        end else if (state == S_SHIFT) begin
            dout  <= step_val;
            carry <= step_cout;
            rem   <= rem - k;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - scoreboard bench for seq_shifter at STEP=1 and STEP=4 (SEQ_SHIFTER_ROR_EN-aware)
module tb_seq_shifter;
    import shifter_pkg::*;

    typedef struct {
        logic [15:0] dout;
        logic        carry;
        int          cyc;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        int          amt;
        logic [15:0] din;
        logic [15:0] ed;
        logic        ec;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_s [2];
    logic [1:0]  op_s    [2];
    logic [3:0]  amt_s   [2];
    logic [15:0] din_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        carry_s [2];
    logic [15:0] dout_s  [2];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t v0[8];
    vec_t v1[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shifter #(.WIDTH(16), .STEP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[0]), .op(op_s[0]), .amount(amt_s[0]),
        .din(din_s[0]), .busy(busy_s[0]), .done(done_s[0]), .dout(dout_s[0]), .carry(carry_s[0])
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) dut4 (
        .clk(clk), .reset(reset), .start(start_s[1]), .op(op_s[1]), .amount(amt_s[1]),
        .din(din_s[1]), .busy(busy_s[1]), .done(done_s[1]), .dout(dout_s[1]), .carry(carry_s[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        int   sz;
        if (done_s[d] === 1'b1) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
                chk($sformatf("spurious_done_dut%0d", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("%s_dout", e.name), 32'(dout_s[d]), 32'(e.dout));
                chk($sformatf("%s_carry", e.name), 32'(carry_s[d]), 32'(e.carry));
                chk($sformatf("%s_cycle", e.name), 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // called at a falling edge; returns at the falling edge after the accept edge
    task automatic issue(input int d, input logic [1:0] op, input int amt, input logic [15:0] din,
                         input logic [15:0] ed, input logic ec, input int lat, input string nm);
        exp_t e;
        start_s[d] = 1'b1;
        op_s[d]    = op;
        amt_s[d]   = 4'(amt);
        din_s[d]   = din;
        e.dout  = ed;
        e.carry = ec;
        e.cyc   = cyc + 1 + lat;
        e.name  = nm;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1 start_s[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int d);
        int n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (((d == 0) ? q0.size() : q1.size()) != 0) begin
            chk($sformatf("timeout_dut%0d", d), 32'd1, 32'd0);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", tag, d),  32'(busy_s[d]),  32'd0);
            chk($sformatf("%s_done%0d", tag, d),  32'(done_s[d]),  32'd0);
            chk($sformatf("%s_dout%0d", tag, d),  32'(dout_s[d]),  32'd0);
            chk($sformatf("%s_carry%0d", tag, d), 32'(carry_s[d]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        v0[0] = '{2'b01,  4, 16'h00FF, 16'h0FF0, 1'b0,  4};
        v0[1] = '{2'b11,  3, 16'h8001, 16'hF000, 1'b0,  3};
        v0[2] = '{2'b10,  1, 16'h0003, 16'h0001, 1'b1,  1};
        v0[3] = '{2'b01,  0, 16'h1234, 16'h1234, 1'b0,  0};
        v0[4] = '{2'b10, 15, 16'hFFFF, 16'h0001, 1'b1, 15};
        v0[5] = '{2'b11, 15, 16'h7FFF, 16'h0000, 1'b1, 15};
`ifdef SEQ_SHIFTER_ROR_EN
        v0[6] = '{2'b00,  7, 16'hBEEF, 16'hDF7D, 1'b1,  7};
        v0[7] = '{2'b00,  1, 16'h0001, 16'h8000, 1'b1,  1};
`else
        v0[6] = '{2'b00,  7, 16'hBEEF, 16'hBEEF, 1'b0,  0};
        v0[7] = '{2'b00,  1, 16'h0001, 16'h0001, 1'b0,  0};
`endif
        v1[0] = '{2'b10,  6, 16'h00F0, 16'h0003, 1'b1,  2};
        v1[1] = '{2'b11, 15, 16'h8000, 16'hFFFF, 1'b0,  4};

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0;
            op_s[d]    = 2'b00;
            amt_s[d]   = 4'd0;
            din_s[d]   = 16'h0;
        end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(0, v0[i].op, v0[i].amt, v0[i].din, v0[i].ed, v0[i].ec, v0[i].lat, $sformatf("s1_vec%0d", i));
            drain(0);
        end
        for (int i = 0; i < 2; i++) begin
            issue(1, v1[i].op, v1[i].amt, v1[i].din, v1[i].ed, v1[i].ec, v1[i].lat, $sformatf("s4_vec%0d", i));
            drain(1);
        end

        // back-to-back: second start is presented during the done cycle
        issue(1, SH_LSL, 5, 16'h0001, 16'h0020, 1'b0, 2, "b2b_lsl");
        n = 0;
        while (done_s[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_wait", 32'(n < 20), 32'd1);
        issue(1, SH_LSR, 5, 16'h0020, 16'h0001, 1'b0, 2, "b2b_lsr");
        drain(1);

        // start during SHIFT must be dropped
        issue(0, SH_LSL, 2, 16'h0003, 16'h000C, 1'b0, 2, "ignore");
        chk("ignore_busy", 32'(busy_s[0]), 32'd1);
        start_s[0] = 1'b1;
        op_s[0]    = SH_LSR;
        amt_s[0]   = 4'd1;
        din_s[0]   = 16'hFFFF;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        drain(0);

        // async reset mid-shift discards the operation
        issue(0, SH_LSL, 8, 16'h00FF, 16'hFF00, 1'b0, 8, "aborted");
        repeat (2) @(negedge clk);
        chk("abort_busy_before", 32'(busy_s[0]), 32'd1);
        #2 reset = 1'b1;
        #1 chk_zero("midreset");
        q0.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, SH_LSR, 2, 16'h8000, 16'h2000, 1'b0, 2, "after_reset");
        drain(0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
